// File: rtl/mac_cluster_feeder_pkg.sv
// Shared types and constants for the MAC cluster feeder: FSM state encoding,
// default cluster widths and a sizing helper.
package mac_cluster_feeder_pkg;

  localparam int unsigned MAC_MIN_WIDTH  = 8;
  localparam int unsigned MAC_ACC_WIDTH  = 32;
  localparam int unsigned MAC_CONF_WIDTH = 4;

  typedef enum logic [1:0] {
    FEED_IDLE  = 2'd0,
    FEED_RUN   = 2'd1,
    FEED_DRAIN = 2'd2,
    FEED_DONE  = 2'd3
  } feed_state_e;

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/mac_cfg_shadow.sv
// Config shadow: collects WORD_W-wide beats LS word first into a shadow register,
// then commits the whole word to the cluster one cycle after the final beat.
module mac_cfg_shadow
  import mac_cluster_feeder_pkg::*;
#(
  parameter int unsigned CFG_W  = 132,
  parameter int unsigned WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              beat_valid,
  input  logic [WORD_W-1:0] beat_data,
  output logic [CFG_W-1:0]  cfg,
  output logic              cfg_loaded,
  output logic              cfg_idle
);

  localparam int unsigned CFG_WORDS = ceil_div(CFG_W, WORD_W);
  localparam int unsigned CNT_W     = (CFG_WORDS > 1) ? $clog2(CFG_WORDS) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CFG_W-1:0] shadow_q, shadow_d;
  logic [CFG_W-1:0] cfg_q, cfg_d;
  logic             commit_q, commit_d;
  logic             loaded_q, loaded_d;

  // The final word may be narrower than WORD_W; its excess beat bits are dropped.
  for (genvar k = 0; k < CFG_WORDS; k++) begin : g_word
    localparam int unsigned LO = k * WORD_W;
    localparam int unsigned NB = (CFG_W - LO < WORD_W) ? (CFG_W - LO) : WORD_W;
    assign shadow_d[LO +: NB] = (beat_valid && cnt_q == CNT_W'(k)) ? beat_data[NB-1:0]
                                                                   : shadow_q[LO +: NB];
  end

  always_comb begin
    cnt_d    = cnt_q;
    cfg_d    = cfg_q;
    commit_d = 1'b0;
    loaded_d = loaded_q;
    if (commit_q) begin
      cfg_d    = shadow_q;
      loaded_d = 1'b1;
    end
    if (beat_valid) begin
      if (cnt_q == '0) loaded_d = 1'b0;
      if (cnt_q == CNT_W'(CFG_WORDS - 1)) begin
        cnt_d    = '0;
        commit_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      cfg_q    <= '0;
      commit_q <= 1'b0;
      loaded_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      cfg_q    <= cfg_d;
      commit_q <= commit_d;
      loaded_q <= loaded_d;
    end
  end

  assign cfg        = cfg_q;
  assign cfg_loaded = loaded_q;
  assign cfg_idle   = (cnt_q == '0);

endmodule

// File: rtl/mac_cluster_feeder.sv
// Upstream feeder for the quad MAC cluster: loads the cluster config, streams
// operand beats with one-cycle enables, drains cluster latency and pulses done.
module mac_cluster_feeder
  import mac_cluster_feeder_pkg::*;
#(
  parameter int unsigned MIN_W    = MAC_MIN_WIDTH,
  parameter int unsigned ACC_W    = MAC_ACC_WIDTH,
  parameter int unsigned CONF_W   = MAC_CONF_WIDTH,
  parameter int unsigned WORD_W   = 32,
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [WORD_W-1:0]         cfg_data,
  input  logic                      op_valid,
  output logic                      op_ready,
  input  logic [8*MIN_W-1:0]        op_data,
  input  logic                      start,
  input  logic [15:0]               op_count,
  output logic [MIN_W-1:0]          A0,
  output logic [MIN_W-1:0]          A1,
  output logic [MIN_W-1:0]          A2,
  output logic [MIN_W-1:0]          A3,
  output logic [MIN_W-1:0]          B0,
  output logic [MIN_W-1:0]          B1,
  output logic [MIN_W-1:0]          B2,
  output logic [MIN_W-1:0]          B3,
  output logic                      en,
  output logic [4*ACC_W+CONF_W-1:0] cfg,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int unsigned CFG_W = 4 * ACC_W + CONF_W;
  localparam int unsigned DRN_W = $clog2(PIPE_LAT) + 1;

  feed_state_e        state_q, state_d;
  logic [15:0]        left_q, left_d;
  logic [DRN_W-1:0]   drain_q, drain_d;
  logic [8*MIN_W-1:0] opnd_q, opnd_d;
  logic               en_q, en_d;
  logic               err_q, err_d;
  logic               cfg_loaded, cfg_idle;

  mac_cfg_shadow #(
    .CFG_W  (CFG_W),
    .WORD_W (WORD_W)
  ) u_cfg_shadow (
    .clk        (clk),
    .rst        (rst),
    .beat_valid (cfg_valid & cfg_ready),
    .beat_data  (cfg_data),
    .cfg        (cfg),
    .cfg_loaded (cfg_loaded),
    .cfg_idle   (cfg_idle)
  );

  always_comb begin
    state_d = state_q;
    left_d  = left_q;
    drain_d = drain_q;
    opnd_d  = opnd_q;
    en_d    = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      FEED_IDLE: begin
        if (start) begin
          if (cfg_loaded && cfg_idle) begin
            if (op_count == '0) begin
              state_d = FEED_DONE;
            end else begin
              left_d  = op_count;
              state_d = FEED_RUN;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      FEED_RUN: begin
        if (op_valid) begin
          opnd_d = op_data;
          en_d   = 1'b1;
          left_d = left_q - 16'd1;
          if (left_q == 16'd1) begin
            drain_d = '0;
            state_d = FEED_DRAIN;
          end
        end
      end
      FEED_DRAIN: begin
        if (drain_q == DRN_W'(PIPE_LAT - 1)) state_d = FEED_DONE;
        else                                 drain_d = drain_q + 1'b1;
      end
      FEED_DONE: state_d = FEED_IDLE;
      default:   state_d = FEED_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FEED_IDLE;
      left_q  <= '0;
      drain_q <= '0;
      opnd_q  <= '0;
      en_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      left_q  <= left_d;
      drain_q <= drain_d;
      opnd_q  <= opnd_d;
      en_q    <= en_d;
      err_q   <= err_d;
    end
  end

  // cfg_ready is masked while rst is held so every output reads 0 in reset.
  assign cfg_ready = (state_q == FEED_IDLE) && !rst;
  assign op_ready  = (state_q == FEED_RUN);
  assign busy      = (state_q == FEED_RUN) || (state_q == FEED_DRAIN);
  assign done      = (state_q == FEED_DONE);
  assign en        = en_q;
  assign err       = err_q;

  assign {B3, A3, B2, A2, B1, A1, B0, A0} = opnd_q;

endmodule

// File: tb/tb_mac_cluster_feeder.sv
// Self-checking bench for mac_cluster_feeder: scenario tasks with a timestamp-based
// reference of accepted beats, enables, drain timing and config contents.
module tb_mac_cluster_feeder;

  localparam int unsigned MIN_W     = 8;
  localparam int unsigned ACC_W     = 32;
  localparam int unsigned CONF_W    = 4;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned PIPE_LAT  = 2;
  localparam int unsigned CFG_W     = 4 * ACC_W + CONF_W;
  localparam int unsigned CFG_WORDS = 5;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cfg_valid = 1'b0;
  logic               cfg_ready;
  logic [WORD_W-1:0]  cfg_data = '0;
  logic               op_valid = 1'b0;
  logic               op_ready;
  logic [8*MIN_W-1:0] op_data = '0;
  logic               start = 1'b0;
  logic [15:0]        op_count = '0;
  logic [MIN_W-1:0]   A0, A1, A2, A3, B0, B1, B2, B3;
  logic               en, busy, done, err;
  logic [CFG_W-1:0]   cfg;

  int checks = 0;
  int errors = 0;

  logic [CFG_WORDS*WORD_W-1:0] cfg_img = '0;
  logic [8*MIN_W-1:0]          exp_ops = '0;

  mac_cluster_feeder #(
    .MIN_W    (MIN_W),
    .ACC_W    (ACC_W),
    .CONF_W   (CONF_W),
    .WORD_W   (WORD_W),
    .PIPE_LAT (PIPE_LAT)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_data   (op_data),
    .start     (start),
    .op_count  (op_count),
    .A0        (A0),
    .A1        (A1),
    .A2        (A2),
    .A3        (A3),
    .B0        (B0),
    .B1        (B1),
    .B2        (B2),
    .B3        (B3),
    .en        (en),
    .cfg       (cfg),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [8*MIN_W-1:0] ops_now();
    return {B3, A3, B2, A2, B1, A1, B0, A0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({en, busy, done, err, op_ready, cfg_ready} !== 6'b0) begin
      errors++;
      $display("FAIL %s ctrl: got en/busy/done/err/op_ready/cfg_ready=%b expected 000000", tag,
               {en, busy, done, err, op_ready, cfg_ready});
    end
    checks++;
    if (ops_now() !== '0) begin
      errors++;
      $display("FAIL %s operands: got %h expected 0", tag, ops_now());
    end
    checks++;
    if (cfg !== '0) begin
      errors++;
      $display("FAIL %s cfg: got %h expected 0", tag, cfg);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    check_all_zero("reset");
    tick();
    rst = 1'b0;
    exp_ops = '0;
    #1;
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_cfg_ready: got %b expected 1", cfg_ready);
    end
  endtask

  task automatic load_cfg(input int unsigned first, input int unsigned last, input bit rnd);
    logic [WORD_W-1:0] w;
    for (int unsigned k = first; k < last; k++) begin
      w = rnd ? WORD_W'($urandom) : WORD_W'((k + 1) * 32'h1111_1111);
      cfg_img[k*WORD_W +: WORD_W] = w;
      cfg_valid = 1'b1;
      cfg_data  = w;
      checks++;
      if (cfg_ready !== 1'b1) begin
        errors++;
        $display("FAIL cfg_ready_word%0d: got %b expected 1", k, cfg_ready);
      end
      tick();
    end
    cfg_valid = 1'b0;
  endtask

  task automatic check_cfg(input string tag);
    checks++;
    if (cfg !== cfg_img[CFG_W-1:0]) begin
      errors++;
      $display("FAIL %s: got cfg %h expected %h", tag, cfg, cfg_img[CFG_W-1:0]);
    end
  endtask

  task automatic start_rejected(input string tag);
    start    = 1'b1;
    op_count = 16'd5;
    tick();
    start = 1'b0;
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse: got err=%b busy=%b expected err=1 busy=0", tag, err, busy);
    end
    tick();
    checks++;
    if (err !== 1'b0 || busy !== 1'b0 || en !== 1'b0) begin
      errors++;
      $display("FAIL %s_after: got err=%b busy=%b en=%b expected 0 0 0", tag, err, busy, en);
    end
  endtask

  // mode 0: op_valid always high, 1: alternating 1,0,1,..., 2: random
  task automatic run_job(input string tag, input int unsigned n, input int mode);
    int unsigned acc = 0;
    int unsigned idx = 0;
    bit          v;
    start    = 1'b1;
    op_count = 16'(n);
    tick();
    start = 1'b0;
    checks++;
    if (busy !== (n != 0)) begin
      errors++;
      $display("FAIL %s_busy_start: got %b expected %b", tag, busy, (n != 0));
    end
    if (n == 0) begin
      checks++;
      if (done !== 1'b1 || en !== 1'b0) begin
        errors++;
        $display("FAIL %s_zero_done: got done=%b en=%b expected 1 0", tag, done, en);
      end
      tick();
      checks++;
      if (done !== 1'b0 || en !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL %s_zero_after: got done=%b en=%b busy=%b expected 0 0 0", tag, done, en, busy);
      end
      return;
    end
    while (acc < n && idx < 200) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (idx % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      op_valid = v;
      op_data  = {$urandom, $urandom};
      checks++;
      if (op_ready !== 1'b1 || cfg_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s_ready_run: got op_ready=%b cfg_ready=%b expected 1 0", tag, op_ready, cfg_ready);
      end
      tick();
      if (v) begin
        acc++;
        exp_ops = op_data;
      end
      checks++;
      if (en !== v) begin
        errors++;
        $display("FAIL %s_en_beat%0d: got %b expected %b", tag, idx, en, v);
      end
      checks++;
      if (ops_now() !== exp_ops) begin
        errors++;
        $display("FAIL %s_ops_beat%0d: got %h expected %h", tag, idx, ops_now(), exp_ops);
      end
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s_busy_beat%0d: got busy=%b done=%b expected 1 0", tag, idx, busy, done);
      end
      idx++;
    end
    if (acc < n) begin
      errors++;
      $display("FAIL %s_timeout: accepted %0d beats, required %0d", tag, acc, n);
    end
    op_valid = 1'b1;
    op_data  = {$urandom, $urandom};
    for (int unsigned d = 1; d <= PIPE_LAT + 1; d++) begin
      checks++;
      if (op_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s_ready_drain%0d: got %b expected 0", tag, d, op_ready);
      end
      tick();
      checks++;
      if (done !== (d == PIPE_LAT) || busy !== (d < PIPE_LAT) || en !== 1'b0) begin
        errors++;
        $display("FAIL %s_drain%0d: got done=%b busy=%b en=%b expected %b %b 0", tag, d,
                 done, busy, en, (d == PIPE_LAT), (d < PIPE_LAT));
      end
      checks++;
      if (ops_now() !== exp_ops) begin
        errors++;
        $display("FAIL %s_ops_drain%0d: got %h expected %h", tag, d, ops_now(), exp_ops);
      end
    end
    op_valid = 1'b0;
  endtask

  task automatic test_cfg_errors();
    start_rejected("err_no_cfg");
    load_cfg(0, 2, 1'b0);
    start_rejected("err_partial_cfg");
    load_cfg(2, CFG_WORDS, 1'b0);
    tick();
    check_cfg("cfg_fixed");
    checks++;
    if (cfg[131:128] !== 4'h5 || cfg[31:0] !== 32'h1111_1111) begin
      errors++;
      $display("FAIL cfg_fields: got top=%h low=%h expected 5 11111111", cfg[131:128], cfg[31:0]);
    end
  endtask

  task automatic test_back_to_back();
    run_job("b2b", 3, 0);
  endtask

  task automatic test_gaps();
    run_job("gaps", 3, 1);
  endtask

  task automatic test_zero_count();
    run_job("zero", 0, 0);
  endtask

  task automatic test_random_jobs();
    load_cfg(0, CFG_WORDS, 1'b1);
    tick();
    check_cfg("cfg_random");
    for (int j = 0; j < 4; j++) run_job("rand", $urandom_range(1, 6), 2);
    check_cfg("cfg_stable");
  endtask

  task automatic test_rst_mid_run();
    start    = 1'b1;
    op_count = 16'd4;
    tick();
    start    = 1'b0;
    op_valid = 1'b1;
    op_data  = {$urandom, $urandom};
    tick();
    op_valid = 1'b0;
    checks++;
    if (en !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: got en=%b busy=%b expected 1 1", en, busy);
    end
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid");
    exp_ops = '0;
    tick();
    rst = 1'b0;
    #1;
    start_rejected("err_after_rst");
    load_cfg(0, CFG_WORDS, 1'b1);
    tick();
    check_cfg("cfg_reload");
    run_job("post_rst", 2, 0);
  endtask

  initial begin
    test_reset();
    test_cfg_errors();
    test_back_to_back();
    test_gaps();
    test_zero_count();
    test_random_jobs();
    test_rst_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
